// File: rtl/mc_ctrl_pkg.sv
// Shared definitions for the multi-cycle control sequencer.
// Holds the state encoding, the opcode constants the sequencer recognises,
// the ALU_op codes (also used by the ALU control block), the branch
// comparison selects and the opcode class used to pick the execute path.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEM_ADDR = 4'd2,
    S_MEM_RD   = 4'd3,
    S_MEM_WB   = 4'd4,
    S_MEM_WR   = 4'd5,
    S_EXEC_R   = 4'd6,
    S_R_WB     = 4'd7,
    S_EXEC_I   = 4'd8,
    S_I_WB     = 4'd9,
    S_BRANCH   = 4'd10,
    S_JUMP     = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_RALT  = 6'd1;
  localparam logic [5:0] OP_J     = 6'd2;
  localparam logic [5:0] OP_BEQ   = 6'd4;
  localparam logic [5:0] OP_BNE   = 6'd5;
  localparam logic [5:0] OP_BLT   = 6'd6;
  localparam logic [5:0] OP_ADDI  = 6'd8;
  localparam logic [5:0] OP_SLTI  = 6'd10;
  localparam logic [5:0] OP_ORI   = 6'd13;
  localparam logic [5:0] OP_LUI   = 6'd15;
  localparam logic [5:0] OP_LW    = 6'd35;
  localparam logic [5:0] OP_SW    = 6'd43;

  localparam logic [3:0] ALU_RTYPE = 4'd0;
  localparam logic [3:0] ALU_BEQ   = 4'd1;
  localparam logic [3:0] ALU_ADD   = 4'd2;
  localparam logic [3:0] ALU_SLTI  = 4'd3;
  localparam logic [3:0] ALU_BNE   = 4'd4;
  localparam logic [3:0] ALU_ORI   = 4'd5;
  localparam logic [3:0] ALU_LUI   = 4'd6;
  localparam logic [3:0] ALU_LW    = 4'd7;
  localparam logic [3:0] ALU_SW    = 4'd8;
  localparam logic [3:0] ALU_J     = 4'd9;
  localparam logic [3:0] ALU_RALT  = 4'd10;
  localparam logic [3:0] ALU_BLT   = 4'd11;

  localparam logic [1:0] BR_DEFAULT = 2'd0;
  localparam logic [1:0] BR_LT      = 2'd2;

  typedef enum logic [2:0] {
    CLS_ILLEGAL = 3'd0,
    CLS_RTYPE   = 3'd1,
    CLS_ITYPE   = 3'd2,
    CLS_MEM     = 3'd3,
    CLS_BRANCH  = 3'd4,
    CLS_JUMP    = 3'd5
  } op_class_t;

endpackage

// File: rtl/mc_op_class.sv
// Combinational opcode classifier.
// Ports:
//   op_i          - opcode field from the instruction register
//   op_class_o    - which execute path the opcode takes
//   alu_op_o      - ALU control code for the opcode
//   branch_type_o - branch comparison select (only meaningful for branches)
//   legal_o       - 1 when the opcode is supported
module mc_op_class
  import mc_ctrl_pkg::*;
(
  input  logic [5:0] op_i,
  output op_class_t  op_class_o,
  output logic [3:0] alu_op_o,
  output logic [1:0] branch_type_o,
  output logic       legal_o
);

  always_comb begin
    op_class_o    = CLS_ILLEGAL;
    alu_op_o      = ALU_RTYPE;
    branch_type_o = BR_DEFAULT;
    legal_o       = 1'b1;
    case (op_i)
      OP_RTYPE: begin op_class_o = CLS_RTYPE;  alu_op_o = ALU_RTYPE; end
      OP_RALT:  begin op_class_o = CLS_RTYPE;  alu_op_o = ALU_RALT;  end
      OP_ADDI:  begin op_class_o = CLS_ITYPE;  alu_op_o = ALU_ADD;   end
      OP_SLTI:  begin op_class_o = CLS_ITYPE;  alu_op_o = ALU_SLTI;  end
      OP_ORI:   begin op_class_o = CLS_ITYPE;  alu_op_o = ALU_ORI;   end
      OP_LUI:   begin op_class_o = CLS_ITYPE;  alu_op_o = ALU_LUI;   end
      OP_LW:    begin op_class_o = CLS_MEM;    alu_op_o = ALU_LW;    end
      OP_SW:    begin op_class_o = CLS_MEM;    alu_op_o = ALU_SW;    end
      OP_BEQ:   begin op_class_o = CLS_BRANCH; alu_op_o = ALU_BEQ;   end
      OP_BNE:   begin op_class_o = CLS_BRANCH; alu_op_o = ALU_BNE;   end
      OP_BLT: begin
        op_class_o    = CLS_BRANCH;
        alu_op_o      = ALU_BLT;
        branch_type_o = BR_LT;
      end
      OP_J:     begin op_class_o = CLS_JUMP;   alu_op_o = ALU_J;     end
      default:  legal_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle Moore control sequencer for the MIPS-subset datapath.
// Steps the shared ALU, unified memory port, register file and PC mux
// through fetch / decode / execute / memory / write-back.
// Ports:
//   clk_i, rst_i           - clock and synchronous active-high reset
//   instr_op_i             - IR opcode field (valid from DECODE onward)
//   mem_ready_i            - memory port completes the current access
//   PCWrite_o .. Branch_type_o - datapath enables and mux selects
//   state_o                - current state for debug
//   instr_done_o           - pulse in the last cycle of each instruction
//   illegal_o              - pulse when DECODE sees an unsupported opcode
//   instr_cnt_o            - retired-instruction counter (wraps)
module multicycle_ctrl
  import mc_ctrl_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [5:0]       instr_op_i,
  input  logic             mem_ready_i,
  output logic             PCWrite_o,
  output logic             PCWriteCond_o,
  output logic [1:0]       PCSource_o,
  output logic             IorD_o,
  output logic             MemRead_o,
  output logic             MemWrite_o,
  output logic             IRWrite_o,
  output logic [1:0]       MemtoReg_o,
  output logic             RegDst_o,
  output logic             RegWrite_o,
  output logic             ALUSrcA_o,
  output logic [1:0]       ALUSrcB_o,
  output logic [3:0]       ALU_op_o,
  output logic [1:0]       Branch_type_o,
  output logic [3:0]       state_o,
  output logic             instr_done_o,
  output logic             illegal_o,
  output logic [CNT_W-1:0] instr_cnt_o
);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  op_class_t  op_class;
  logic [3:0] op_alu;
  logic [1:0] op_br_type;
  logic       op_legal;

  mc_op_class u_op_class (
    .op_i          (instr_op_i),
    .op_class_o    (op_class),
    .alu_op_o      (op_alu),
    .branch_type_o (op_br_type),
    .legal_o       (op_legal)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_FETCH;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state and Moore outputs; the only input-dependent outputs are the
  // memory-ready qualified ones in FETCH and MEM_WR. Reset gates every
  // output so nothing is written while the sequencer is being cleared.
  always_comb begin
    state_d       = state_q;
    PCWrite_o     = 1'b0;
    PCWriteCond_o = 1'b0;
    PCSource_o    = 2'd0;
    IorD_o        = 1'b0;
    MemRead_o     = 1'b0;
    MemWrite_o    = 1'b0;
    IRWrite_o     = 1'b0;
    MemtoReg_o    = 2'd0;
    RegDst_o      = 1'b0;
    RegWrite_o    = 1'b0;
    ALUSrcA_o     = 1'b0;
    ALUSrcB_o     = 2'd0;
    ALU_op_o      = 4'd0;
    Branch_type_o = 2'd0;
    instr_done_o  = 1'b0;
    illegal_o     = 1'b0;

    case (state_q)
      S_FETCH: begin
        MemRead_o = 1'b1;
        ALUSrcB_o = 2'd1;
        ALU_op_o  = ALU_ADD;
        IRWrite_o = mem_ready_i;
        PCWrite_o = mem_ready_i;
        if (mem_ready_i) state_d = S_DECODE;
      end
      S_DECODE: begin
        // Branch target is precomputed into ALUOut here.
        ALUSrcB_o = 2'd3;
        ALU_op_o  = ALU_ADD;
        case (op_class)
          CLS_RTYPE:  state_d = S_EXEC_R;
          CLS_ITYPE:  state_d = S_EXEC_I;
          CLS_MEM:    state_d = S_MEM_ADDR;
          CLS_BRANCH: state_d = S_BRANCH;
          CLS_JUMP:   state_d = S_JUMP;
          default:    state_d = S_FETCH;
        endcase
        illegal_o = ~op_legal;
      end
      S_EXEC_R: begin
        ALUSrcA_o = 1'b1;
        ALU_op_o  = op_alu;
        state_d   = S_R_WB;
      end
      S_R_WB: begin
        RegDst_o     = 1'b1;
        RegWrite_o   = 1'b1;
        instr_done_o = 1'b1;
        state_d      = S_FETCH;
      end
      S_EXEC_I: begin
        ALUSrcA_o = 1'b1;
        ALUSrcB_o = 2'd2;
        ALU_op_o  = op_alu;
        state_d   = S_I_WB;
      end
      S_I_WB: begin
        RegWrite_o   = 1'b1;
        instr_done_o = 1'b1;
        state_d      = S_FETCH;
      end
      S_MEM_ADDR: begin
        ALUSrcA_o = 1'b1;
        ALUSrcB_o = 2'd2;
        ALU_op_o  = op_alu;
        state_d   = (instr_op_i == OP_LW) ? S_MEM_RD : S_MEM_WR;
      end
      S_MEM_RD: begin
        MemRead_o = 1'b1;
        IorD_o    = 1'b1;
        if (mem_ready_i) state_d = S_MEM_WB;
      end
      S_MEM_WB: begin
        RegWrite_o   = 1'b1;
        MemtoReg_o   = 2'd1;
        instr_done_o = 1'b1;
        state_d      = S_FETCH;
      end
      S_MEM_WR: begin
        MemWrite_o   = 1'b1;
        IorD_o       = 1'b1;
        instr_done_o = mem_ready_i;
        if (mem_ready_i) state_d = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcA_o     = 1'b1;
        ALU_op_o      = op_alu;
        PCWriteCond_o = 1'b1;
        PCSource_o    = 2'd1;
        Branch_type_o = op_br_type;
        instr_done_o  = 1'b1;
        state_d       = S_FETCH;
      end
      S_JUMP: begin
        PCWrite_o    = 1'b1;
        PCSource_o   = 2'd2;
        instr_done_o = 1'b1;
        state_d      = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase

    if (rst_i) begin
      PCWrite_o     = 1'b0;
      PCWriteCond_o = 1'b0;
      PCSource_o    = 2'd0;
      IorD_o        = 1'b0;
      MemRead_o     = 1'b0;
      MemWrite_o    = 1'b0;
      IRWrite_o     = 1'b0;
      MemtoReg_o    = 2'd0;
      RegDst_o      = 1'b0;
      RegWrite_o    = 1'b0;
      ALUSrcA_o     = 1'b0;
      ALUSrcB_o     = 2'd0;
      ALU_op_o      = 4'd0;
      Branch_type_o = 2'd0;
      instr_done_o  = 1'b0;
      illegal_o     = 1'b0;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (instr_done_o) cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
  end

  assign state_o     = state_q;
  assign instr_cnt_o = cnt_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed self-checking bench for multicycle_ctrl, built with a 4-bit
// retired-instruction counter so the wrap can be exercised quickly.
module tb_multicycle_ctrl;

  logic       clk;
  logic       rst;
  logic [5:0] op;
  logic       ready;
  logic       pcWrite, pcWriteCond, iorD, memRead, memWrite, irWrite;
  logic       regDst, regWrite, aluSrcA, instrDone, illegal;
  logic [1:0] pcSource, memtoReg, aluSrcB, branchType;
  logic [3:0] aluOp, state;
  logic [3:0] instrCnt;

  int total = 0;
  int bad   = 0;

  multicycle_ctrl #(.CNT_W(4)) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .instr_op_i    (op),
    .mem_ready_i   (ready),
    .PCWrite_o     (pcWrite),
    .PCWriteCond_o (pcWriteCond),
    .PCSource_o    (pcSource),
    .IorD_o        (iorD),
    .MemRead_o     (memRead),
    .MemWrite_o    (memWrite),
    .IRWrite_o     (irWrite),
    .MemtoReg_o    (memtoReg),
    .RegDst_o      (regDst),
    .RegWrite_o    (regWrite),
    .ALUSrcA_o     (aluSrcA),
    .ALUSrcB_o     (aluSrcB),
    .ALU_op_o      (aluOp),
    .Branch_type_o (branchType),
    .state_o       (state),
    .instr_done_o  (instrDone),
    .illegal_o     (illegal),
    .instr_cnt_o   (instrCnt)
  );

   // Free-running 10 ns clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Single comparison point: counts every check and reports any mismatch.
   task automatic checkOutput(input string tag, input logic [31:0] actual,
                              input logic [31:0] expected);
      total++;
      if (actual !== expected) begin
         bad++;
         $display("[TB] FAIL %s: got %0d expected %0d", tag, actual, expected);
      end
   endtask

   // Drive inputs, then let the combinational outputs settle.
   task automatic applyStimulus(input logic [5:0] opIn, input logic readyIn);
      op    = opIn;
      ready = readyIn;
      #1;
   endtask

   // Advance one clock and land safely past the active edge.
   task automatic stepClock();
      @(posedge clk);
      #2;
   endtask

   // Fetch-to-fetch run of a jump with no memory wait.
   task automatic runJump();
      applyStimulus(6'd2, 1'b1);
      stepClock();
      stepClock();
      stepClock();
   endtask

   // Every output that reset must hold low, packed together.
   function automatic logic [31:0] allOutputs();
      return {6'd0, pcWrite, pcWriteCond, pcSource, iorD, memRead, memWrite,
              irWrite, memtoReg, regDst, regWrite, aluSrcA, aluSrcB, aluOp,
              branchType, instrDone, illegal};
   endfunction

   // Directed scenarios in order; expected counts are tracked by hand.
   initial begin
      int cycles;
      rst   = 1'b1;
      op    = 6'd0;
      ready = 1'b1;
      #1;

      // Reset held for three cycles with memory ready.
      for (int i = 0; i < 3; i++) begin
         stepClock();
         checkOutput("reset_outputs_zero", allOutputs(), 32'd0);
      end
      rst = 1'b0;
      applyStimulus(6'd0, 1'b1);
      checkOutput("reset_state", state, 32'd0);
      checkOutput("reset_cnt", instrCnt, 32'd0);
      checkOutput("fetch_irwrite", irWrite, 32'd1);
      checkOutput("fetch_pcwrite", pcWrite, 32'd1);
      checkOutput("fetch_alusrcb", aluSrcB, 32'd1);

      // R-type opcode 0.
      stepClock();
      checkOutput("r_decode_state", state, 32'd1);
      checkOutput("r_decode_alusrcb", aluSrcB, 32'd3);
      stepClock();
      checkOutput("r_exec_state", state, 32'd6);
      checkOutput("r_exec_regwrite", regWrite, 32'd0);
      checkOutput("r_exec_aluop", aluOp, 32'd0);
      checkOutput("r_exec_alusrca", aluSrcA, 32'd1);
      stepClock();
      checkOutput("r_wb_state", state, 32'd7);
      checkOutput("r_wb_regwrite", regWrite, 32'd1);
      checkOutput("r_wb_regdst", regDst, 32'd1);
      checkOutput("r_wb_done", instrDone, 32'd1);
      stepClock();
      checkOutput("r_back_fetch", state, 32'd0);

      // addi opcode 8.
      applyStimulus(6'd8, 1'b1);
      stepClock();
      checkOutput("i_decode_state", state, 32'd1);
      stepClock();
      checkOutput("i_exec_state", state, 32'd8);
      checkOutput("i_exec_aluop", aluOp, 32'd2);
      checkOutput("i_exec_alusrcb", aluSrcB, 32'd2);
      checkOutput("i_exec_regwrite", regWrite, 32'd0);
      stepClock();
      checkOutput("i_wb_state", state, 32'd9);
      checkOutput("i_wb_regwrite", regWrite, 32'd1);
      checkOutput("i_wb_regdst", regDst, 32'd0);
      stepClock();
      checkOutput("ri_cnt", instrCnt, 32'd2);

      // lw with two fetch waits and three MEM_RD waits: 10 cycles.
      cycles = 0;
      for (int i = 0; i < 2; i++) begin
         applyStimulus(6'd35, 1'b0);
         checkOutput("lw_fetch_wait_state", state, 32'd0);
         checkOutput("lw_fetch_wait_irwrite", irWrite, 32'd0);
         checkOutput("lw_fetch_wait_memread", memRead, 32'd1);
         stepClock();
         cycles++;
      end
      applyStimulus(6'd35, 1'b1);
      checkOutput("lw_fetch_ready_irwrite", irWrite, 32'd1);
      stepClock();
      cycles++;
      checkOutput("lw_decode_state", state, 32'd1);
      stepClock();
      cycles++;
      checkOutput("lw_addr_state", state, 32'd2);
      checkOutput("lw_addr_aluop", aluOp, 32'd7);
      stepClock();
      cycles++;
      for (int i = 0; i < 3; i++) begin
         applyStimulus(6'd35, 1'b0);
         checkOutput("lw_rd_wait_state", state, 32'd3);
         checkOutput("lw_rd_iord", iorD, 32'd1);
         stepClock();
         cycles++;
      end
      applyStimulus(6'd35, 1'b1);
      checkOutput("lw_rd_ready_state", state, 32'd3);
      stepClock();
      cycles++;
      checkOutput("lw_wb_state", state, 32'd4);
      checkOutput("lw_wb_memtoreg", memtoReg, 32'd1);
      checkOutput("lw_wb_regwrite", regWrite, 32'd1);
      checkOutput("lw_wb_done", instrDone, 32'd1);
      stepClock();
      cycles++;
      checkOutput("lw_cycles", cycles, 32'd10);
      checkOutput("lw_back_fetch", state, 32'd0);
      checkOutput("lw_cnt", instrCnt, 32'd3);

      // beq (4) then blt (6).
      applyStimulus(6'd4, 1'b1);
      stepClock();
      stepClock();
      checkOutput("beq_state", state, 32'd10);
      checkOutput("beq_pcwritecond", pcWriteCond, 32'd1);
      checkOutput("beq_aluop", aluOp, 32'd1);
      checkOutput("beq_branchtype", branchType, 32'd0);
      checkOutput("beq_pcsource", pcSource, 32'd1);
      stepClock();
      checkOutput("beq_back_fetch", state, 32'd0);
      applyStimulus(6'd6, 1'b1);
      stepClock();
      stepClock();
      checkOutput("blt_state", state, 32'd10);
      checkOutput("blt_aluop", aluOp, 32'd11);
      checkOutput("blt_branchtype", branchType, 32'd2);
      checkOutput("blt_done", instrDone, 32'd1);
      stepClock();
      checkOutput("blt_back_fetch", state, 32'd0);
      checkOutput("branch_cnt", instrCnt, 32'd5);

      // Jump, then illegal opcode 63.
      applyStimulus(6'd2, 1'b1);
      stepClock();
      stepClock();
      checkOutput("jump_state", state, 32'd11);
      checkOutput("jump_pcwrite", pcWrite, 32'd1);
      checkOutput("jump_pcsource", pcSource, 32'd2);
      stepClock();
      checkOutput("jump_cnt", instrCnt, 32'd6);
      applyStimulus(6'd63, 1'b1);
      stepClock();
      checkOutput("ill_decode_state", state, 32'd1);
      checkOutput("ill_pulse", illegal, 32'd1);
      checkOutput("ill_no_done", instrDone, 32'd0);
      stepClock();
      checkOutput("ill_back_fetch", state, 32'd0);
      checkOutput("ill_cnt", instrCnt, 32'd6);
      checkOutput("ill_pulse_clear", illegal, 32'd0);

      // sw with one MEM_WR wait, retiring on the ready cycle.
      applyStimulus(6'd43, 1'b1);
      stepClock();
      stepClock();
      checkOutput("sw_addr_aluop", aluOp, 32'd8);
      stepClock();
      applyStimulus(6'd43, 1'b0);
      checkOutput("sw_wr_state", state, 32'd5);
      checkOutput("sw_wait_no_done", instrDone, 32'd0);
      checkOutput("sw_memwrite", memWrite, 32'd1);
      stepClock();
      applyStimulus(6'd43, 1'b1);
      checkOutput("sw_ready_done", instrDone, 32'd1);
      stepClock();
      checkOutput("sw_back_fetch", state, 32'd0);
      checkOutput("sw_cnt", instrCnt, 32'd7);

      // sw aborted by reset during the MEM_WR wait.
      applyStimulus(6'd43, 1'b1);
      stepClock();
      stepClock();
      stepClock();
      applyStimulus(6'd43, 1'b0);
      checkOutput("abort_wr_state", state, 32'd5);
      rst = 1'b1;
      #1;
      checkOutput("abort_rst_memwrite", memWrite, 32'd0);
      checkOutput("abort_rst_done", instrDone, 32'd0);
      stepClock();
      rst = 1'b0;
      applyStimulus(6'd43, 1'b0);
      checkOutput("abort_state", state, 32'd0);
      checkOutput("abort_memwrite", memWrite, 32'd0);
      checkOutput("abort_done", instrDone, 32'd0);
      checkOutput("abort_cnt", instrCnt, 32'd0);

      // 17 retired jumps wrap a 4-bit counter to 1.
      for (int i = 0; i < 15; i++) runJump();
      checkOutput("wrap_cnt15", instrCnt, 32'd15);
      runJump();
      checkOutput("wrap_cnt16", instrCnt, 32'd0);
      runJump();
      checkOutput("wrap_cnt17", instrCnt, 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Multi-cycle control sequencer for the MIPS-subset datapath. It replaces single-cycle opcode decoding with a Moore state machine that steps the shared ALU, a single unified memory port, the register file and the PC mux through fetch, decode, execute, memory and write-back. Instruction and data accesses share one memory port, which can stall the sequencer through a ready handshake. The block sits between the instruction register's opcode field and every datapath enable and mux select.

## Interface
- `CNT_W`, 16: width of the retired-instruction counter.
- `clk_i` in 1: clock; all state updates on the rising edge.
- `rst_i` in 1: synchronous, active-high reset.
- `instr_op_i` in 6: opcode from the instruction register; valid from DECODE onward.
- `mem_ready_i` in 1: memory port completes the current access this cycle.
- `PCWrite_o` out 1: unconditional PC load.
- `PCWriteCond_o` out 1: PC load qualified by the datapath branch comparison.
- `PCSource_o` out 2: 0 = ALU result, 1 = ALUOut register, 2 = jump target.
- `IorD_o` out 1: memory address source; 0 = PC, 1 = ALUOut.
- `MemRead_o` out 1: memory read request.
- `MemWrite_o` out 1: memory write request.
- `IRWrite_o` out 1: instruction register load.
- `MemtoReg_o` out 2: write-back source; 0 = ALUOut, 1 = MDR.
- `RegDst_o` out 1: destination register; 1 = rd, 0 = rt.
- `RegWrite_o` out 1: register file write.
- `ALUSrcA_o` out 1: ALU A input; 0 = PC, 1 = rs.
- `ALUSrcB_o` out 2: ALU B input; 0 = rt, 1 = constant 4, 2 = sign-extended immediate, 3 = shifted immediate.
- `ALU_op_o` out 4: ALU control code.
- `Branch_type_o` out 2: branch comparison select for the PCWriteCond qualifier.
- `state_o` out 4: current state, for debug.
- `instr_done_o` out 1: one-cycle pulse in the final cycle of each instruction.
- `illegal_o` out 1: one-cycle pulse when DECODE sees an unsupported opcode.
- `instr_cnt_o` out `CNT_W`: retired-instruction count.

## Operation
- **States (4-bit):** FETCH=0, DECODE=1, MEM_ADDR=2, MEM_RD=3, MEM_WB=4, MEM_WR=5, EXEC_R=6, R_WB=7, EXEC_I=8, I_WB=9, BRANCH=10, JUMP=11. Encodings 12–15 are unreachable and return to FETCH.
- **FETCH:** MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=1, ALU_op=2 (add), PCSource=0.
  - IRWrite and PCWrite equal `mem_ready_i`.
  - Stay in FETCH until `mem_ready_i`=1, then go to DECODE.
- **DECODE:** ALUSrcA=0, ALUSrcB=3, ALU_op=2. This precomputes the branch target into ALUOut. Next state by opcode:
  - 0 or 1 → EXEC_R
  - 8, 10, 13, 15 → EXEC_I
  - 35 or 43 → MEM_ADDR
  - 4, 5, 6 → BRANCH
  - 2 → JUMP
  - any other opcode → FETCH, with `illegal_o` pulsed and `instr_done_o` not pulsed
- **ALU_op by opcode:** 0→0, 1→10, 4→1, 5→4, 6→11, 8→2, 10→3, 13→5, 15→6, 35→7, 43→8, 2→9.
- **EXEC_R:** ALUSrcA=1, ALUSrcB=0, ALU_op per opcode.
- **R_WB:** RegDst=1, RegWrite=1, MemtoReg=0; instruction done.
- **EXEC_I:** ALUSrcA=1, ALUSrcB=2, ALU_op per opcode.
- **I_WB:** RegDst=0, RegWrite=1, MemtoReg=0; instruction done.
- **MEM_ADDR:** ALUSrcA=1, ALUSrcB=2, ALU_op 7 (lw) or 8 (sw). Next state is MEM_RD for opcode 35, MEM_WR for opcode 43.
- **MEM_RD:** MemRead=1, IorD=1. Hold until `mem_ready_i`=1, then go to MEM_WB.
- **MEM_WB:** RegDst=0, RegWrite=1, MemtoReg=1; instruction done.
- **MEM_WR:** MemWrite=1, IorD=1. Hold until `mem_ready_i`=1; done on the ready cycle.
- **BRANCH:** ALUSrcA=1, ALUSrcB=0, ALU_op per opcode, PCWriteCond=1, PCSource=1.
  - Branch_type=2 for opcode 6, otherwise 0.
  - Instruction done.
- **JUMP:** PCWrite=1, PCSource=2; instruction done.
- **Defaults:** any output not listed for a state is 0.
- **Instruction done:** in the done cycle, `instr_done_o`=1, `instr_cnt_o` increments (wrapping at 2^CNT_W), and the next state is FETCH.

## Timing
- **Outputs:** decoded from the registered state (Moore). The only combinational input paths are `mem_ready_i` → IRWrite/PCWrite in FETCH, and `mem_ready_i` → `instr_done_o` in MEM_WR.
- **Latency with zero memory wait (`mem_ready_i` tied 1):**
  - R-type and I-type: 4 cycles
  - lw: 5 cycles
  - sw: 4 cycles
  - branch and jump: 3 cycles
  - illegal opcode: 2 cycles
- **Memory wait:** each wait cycle in FETCH, MEM_RD or MEM_WR adds one cycle. No other state stalls.
- **Reset:**
  - While `rst_i`=1, all outputs except `state_o` are forced to 0, so no writes reach the PC, IR, memory or register file.
  - At the next edge the state becomes FETCH and `instr_cnt_o` becomes 0.
  - Reset asserted mid-instruction, including during a memory wait, aborts the instruction with no retire pulse.
- **Opcode sampling:** `instr_op_i` is sampled in DECODE, EXEC_*, MEM_ADDR and BRANCH. The IR is stable there because IRWrite=0 outside FETCH.

## Structure
- **Shared package `mc_ctrl_pkg`:** state encoding constants, opcode constants (OP_RTYPE=0 … OP_SW=43), and ALU_op codes 0–11. The ALU control block uses the same ALU_op codes.
- **Sub-module `mc_op_class`:** combinational opcode → {class, ALU_op, Branch_type, legal}. It is shared by the DECODE next-state logic and the EXEC/BRANCH output logic.

## Test plan
- **Reset:** hold `rst_i`=1 for 3 cycles with `mem_ready_i`=1 → all write enables are 0; after release, state_o=0 and instr_cnt_o=0.
- **R-type and addi:** opcode 0, then 8, with `mem_ready_i`=1 → state sequence 0,1,6,7 then 0,1,8,9; RegWrite=1 only in states 7 and 9; instr_cnt_o=2.
- **lw with memory waits:** opcode 35, `mem_ready_i` low for 2 cycles in FETCH and 3 cycles in MEM_RD → 10 cycles total; IRWrite=1 only on the ready cycle; MemtoReg=1 in MEM_WB.
- **Branches:** opcodes 4, then 6 → each takes 3 cycles; PCWriteCond=1 in state 10 with ALU_op 1 and then 11; Branch_type=2 only for opcode 6.
- **Jump, then illegal opcode:** opcode 2, then opcode 63 → JUMP asserts PCWrite=1 with PCSource=2; opcode 63 pulses illegal_o and returns to FETCH after 2 cycles with instr_cnt_o unchanged.
- **Mid-instruction reset and counter wrap:**
  - Assert `rst_i` during MEM_WR wait → no MemWrite and no instr_done_o on the next cycle.
  - With CNT_W=4, retire 17 instructions → instr_cnt_o=1.
